// File: rtl/acesso_if.sv
// Request/grant bundle between the requesting profiles, the priority comparator
// and the grant stage of the shared resource.
interface acesso_if;
    logic       req0;
    logic       req1;
    logic       prio0;
    logic       prio1;
    logic       grant0;
    logic       grant1;
    logic       busy;
    logic       timeout;
    logic [2:0] estado;

    modport master (
        output req0, req1, prio0, prio1,
        input  grant0, grant1, busy, timeout, estado
    );

    modport slave (
        input  req0, req1, prio0, prio1,
        output grant0, grant1, busy, timeout, estado
    );
endinterface

// File: rtl/controle_acesso_recurso.sv
// Registered grant stage for the shared resource: IDLE/G0/G1/BOTH/GUARD FSM.
// Define ACESSO_TIMEOUT_EN to add the hold timer, timeout pulse and per-profile lockout.
module controle_acesso_recurso #(
    parameter int TEMPO_MAX = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    acesso_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        G0    = 3'd1,
        G1    = 3'd2,
        BOTH  = 3'd3,
        GUARD = 3'd4
    } estado_t;

    if (TEMPO_MAX < 2 || TEMPO_MAX > 255) begin : g_tempo_invalido
        $error("TEMPO_MAX must be within 2..255");
    end

    estado_t state;
    estado_t state_next;
    logic    e0;
    logic    e1;

`ifdef ACESSO_TIMEOUT_EN
    localparam logic [7:0] LIMITE = 8'(TEMPO_MAX - 1);

    logic [7:0] timer;
    logic       lock0;
    logic       lock1;
    logic       set0;
    logic       set1;
    logic       expira;
    logic       timeout_q;

    // The owner is still requesting whenever this is consulted; a drop wins first.
    assign expira = (timer == LIMITE);
    assign e0     = bus.req0 & bus.prio0 & ~lock0;
    assign e1     = bus.req1 & bus.prio1 & ~lock1;
`else
    assign e0     = bus.req0 & bus.prio0;
    assign e1     = bus.req1 & bus.prio1;
`endif

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
`ifdef ACESSO_TIMEOUT_EN
        set0 = 1'b0;
        set1 = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (e0 && e1)  state_next = BOTH;
                else if (e0)   state_next = G0;
                else if (e1)   state_next = G1;
            end
            G0: begin
                if (!bus.req0) state_next = GUARD;
`ifdef ACESSO_TIMEOUT_EN
                else if (expira) begin
                    state_next = GUARD;
                    set0       = 1'b1;
                end
`endif
            end
            G1: begin
                if (!bus.req1) state_next = GUARD;
`ifdef ACESSO_TIMEOUT_EN
                else if (expira) begin
                    state_next = GUARD;
                    set1       = 1'b1;
                end
`endif
            end
            BOTH: begin
                if (!bus.req0 && !bus.req1) state_next = GUARD;
                else if (!bus.req0)         state_next = G1;
                else if (!bus.req1)         state_next = G0;
`ifdef ACESSO_TIMEOUT_EN
                else if (expira) begin
                    state_next = GUARD;
                    set0       = 1'b1;
                    set1       = 1'b1;
                end
`endif
            end
            GUARD:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

`ifdef ACESSO_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer     <= '0;
            lock0     <= 1'b0;
            lock1     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= set0 | set1;
            lock0     <= (lock0 & bus.req0) | set0;
            lock1     <= (lock1 & bus.req1) | set1;
            // Any state change (including BOTH -> single owner) restarts the hold window.
            if (state_next != state)
                timer <= '0;
            else if (state == G0 || state == G1 || state == BOTH)
                timer <= timer + 8'd1;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.grant0 = (state == G0) || (state == BOTH);
    assign bus.grant1 = (state == G1) || (state == BOTH);
    assign bus.busy   = (state == G0) || (state == G1) || (state == BOTH);
    assign bus.estado = state;

endmodule
